blt_uart_write: RTL

Bluetooth-UART transmitter driving the blt_wx line to the HC-05 style module, the outbound partner of the Bluetooth receive path.
- Game logic pushes bytes (score digits, status characters such as "S", "G") through a single-cycle write strobe into an internal FIFO.
- The block serialises each byte as 8N1 at a fixed baud rate, LSB first.
- It sits at top level beside the receiver; its blt_wx output connects directly to the pin.

---
 rtl/blt_uart_pkg.sv | 28 ++
 rtl/blt_tx_fifo.sv | 99 +++++++++
 rtl/blt_uart_write.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/blt_uart_pkg.sv
// ----------------------------------------------------------------------------
// blt_uart_pkg
// Definitions shared by the Bluetooth UART transmit and receive paths:
//   - the frame state encoding (IDLE / START / DATA / STOP)
//   - the frame geometry (8 data bits, idle line level high)
//   - the default clock and baud constants
//   - a helper that turns clock and baud into a bit period in clocks
// ----------------------------------------------------------------------------
package blt_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int   FRAME_DATA_BITS   = 8;
    localparam logic LINE_IDLE         = 1'b1;
    localparam int   DEFAULT_CLK_FREQ  = 50_000_000;
    localparam int   DEFAULT_BAUD_RATE = 9600;

    // Clocks per serial bit. Integer division truncates, so 50 MHz / 9600 gives 5208.
    function automatic int calc_bit_cnt(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage : blt_uart_pkg

// File: rtl/blt_tx_fifo.sv
// ----------------------------------------------------------------------------
// blt_tx_fifo
// Synchronous byte FIFO that buffers outbound UART bytes.
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-low reset (empties the FIFO)
//   wr_en - push din; ignored while full (even if a pop happens on the same edge)
//   din   - byte to push
//   rd_en - pop the head; ignored while empty
//   dout  - head of the FIFO (first-word fall-through)
//   full  - registered, high when DEPTH bytes are stored
//   empty - registered, high when no byte is stored
// DEPTH must be a power of two and at least 2, so the pointers wrap on their own.
// ----------------------------------------------------------------------------
module blt_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] din,
    input  logic       rd_en,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             wr_fire_s;
    logic             rd_fire_s;

    // Pointer, occupancy and flag update; flags are derived from the next count so
    // they are registered together with it.
    always_comb begin
        wr_fire_s = wr_en & ~full_q;
        rd_fire_s = rd_en & ~empty_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;

        if (wr_fire_s) begin
            wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_fire_s) begin
            rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_fire_s, rd_fire_s})
            2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == {CNT_W{1'b0}});
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule : blt_tx_fifo

// File: rtl/blt_uart_write.sv
// ----------------------------------------------------------------------------
// blt_uart_write
// Bluetooth UART transmitter: buffers bytes from game logic and sends each one
// as an 8N1 frame, LSB first, on the blt_wx pin.
// Ports:
//   clk     - system clock, rising edge
//   rst     - synchronous active-low reset; aborts any frame and flushes the FIFO
//   data_in - byte to send
//   wr_en   - write strobe, one byte per cycle while full is low
//   full    - transmit FIFO holds FIFO_DEPTH bytes
//   busy    - a frame is on the line
//   tx_done - one-cycle pulse in the last clock of each stop bit
//   blt_wx  - serial output, idle high
// ----------------------------------------------------------------------------
module blt_uart_write
    import blt_uart_pkg::*;
#(
    parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       wr_en,
    output logic       full,
    output logic       busy,
    output logic       tx_done,
    output logic       blt_wx
);

    localparam int         BIT_CNT      = calc_bit_cnt(CLK_FREQ, BAUD_RATE);
    localparam int         TMR_W        = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BIT_CNT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [2:0] LAST_BIT_IDX = 3'(FRAME_DATA_BITS - 1);

    uart_state_e      state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pop_s;
    logic             timer_last_s;
    logic [7:0]       fifo_dout_s;
    logic             fifo_empty_s;
    logic             fifo_full_s;

    blt_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .din   (data_in),
        .rd_en (pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Frame sequencer: next state, bit timer, shift register and next line level.
    // The timer restarts at every state or bit change, so frames never drift.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        pop_s        = 1'b0;
        timer_last_s = (timer_q == TMR_LAST);

        case (state_q)
            ST_IDLE: begin
                tx_d = LINE_IDLE;
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = fifo_dout_s;
                    timer_d = {TMR_W{1'b0}};
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (timer_last_s) begin
                    timer_d   = {TMR_W{1'b0}};
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                    state_d   = ST_DATA;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            ST_DATA: begin
                if (timer_last_s) begin
                    timer_d = {TMR_W{1'b0}};
                    if (bit_idx_q == LAST_BIT_IDX) begin
                        tx_d    = LINE_IDLE;
                        state_d = ST_STOP;
                    end else begin
                        // Next bit is shift_q[1], which becomes shift[0] after the shift.
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            ST_STOP: begin
                if (timer_last_s) begin
                    timer_d = {TMR_W{1'b0}};
                    if (!fifo_empty_s) begin
                        // Back-to-back frame: start bit begins on this very edge.
                        pop_s   = 1'b1;
                        shift_d = fifo_dout_s;
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else begin
                        tx_d    = LINE_IDLE;
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            default: begin
                timer_d = {TMR_W{1'b0}};
                tx_d    = LINE_IDLE;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        // Registered pulse: raised on the edge that enters the final stop-bit clock.
        done_d = (state_d == ST_STOP) && (timer_d == TMR_LAST);
    end

    // Sequencer and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= {TMR_W{1'b0}};
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= LINE_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign blt_wx  = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;
    assign full    = fifo_full_s;

endmodule : blt_uart_write
